// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and the data-access controller state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    HALT   = 2'd3
  } dmem_state_t;

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// EX/MEM-side inputs, data-memory port and pipeline control outputs of the
// memory-stage access controller, bundled for port connection.
interface dmem_access_ctrl_if #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
);

  logic              dmemREN_i;
  logic              dmemWEN_i;
  logic [WORD_W-1:0] dmemaddr_i;
  logic [WORD_W-1:0] dmemstore_i;
  logic              halt_i;
  logic              ihit;
  logic              dhit;
  logic [WORD_W-1:0] dmemload;

  logic              dmemREN;
  logic              dmemWEN;
  logic [WORD_W-1:0] dmemaddr;
  logic [WORD_W-1:0] dmemstore;
  logic [WORD_W-1:0] dmem_load_o;
  logic              freeze_o;
  logic              halt_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  // Controller side: drives memory requests and pipeline control.
  modport master (
    input  dmemREN_i, dmemWEN_i, dmemaddr_i, dmemstore_i, halt_i, ihit, dhit, dmemload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, dmem_load_o, freeze_o, halt_o, stall_cnt_o
  );

  // Environment side: pipeline latch, fetch unit and memory model.
  modport slave (
    output dmemREN_i, dmemWEN_i, dmemaddr_i, dmemstore_i, halt_i, ihit, dhit, dmemload,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, dmem_load_o, freeze_o, halt_o, stall_cnt_o
  );

endinterface

// File: rtl/dmem_access_ctrl.sv
// Memory-stage data-access controller: holds a load/store request until dhit,
// registers load data, and generates the global pipeline freeze and sticky halt.
module dmem_access_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int WORD_W = 32
) (
  input  logic           CLK,
  input  logic           nRST,
  dmem_access_ctrl_if.master bus
);

  dmem_state_t       state;
  dmem_state_t       state_nxt;
  logic              req_ren;
  logic              req_wen;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_store;
  logic [WORD_W-1:0] load_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              memop;
  logic              issue;
  logic              capture;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign memop   = bus.dmemREN_i | bus.dmemWEN_i;
  assign issue   = (state == IDLE) && memop;
  assign capture = (state == ACCESS) && bus.dhit && req_ren;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  // Request op type is control; a simultaneous load+store is issued as a store.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      req_ren <= 1'b0;
      req_wen <= 1'b0;
    end else if (issue) begin
      req_ren <= bus.dmemREN_i & ~bus.dmemWEN_i;
      req_wen <= bus.dmemWEN_i;
    end
  end

  always_ff @(posedge CLK) begin
    if (issue) begin
      req_addr  <= bus.dmemaddr_i;
      req_store <= bus.dmemstore_i;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      load_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (capture)          load_q <= bus.dmemload;
      if (state == ACCESS)  cnt_q  <= sat_inc(cnt_q);
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.freeze_o  = 1'b1;
    bus.dmemREN   = 1'b0;
    bus.dmemWEN   = 1'b0;
    bus.dmemaddr  = '0;
    bus.dmemstore = '0;
    case (state)
      IDLE: begin
        bus.freeze_o = memop | ~bus.ihit;
        if (memop)                       state_nxt = ACCESS;
        else if (bus.halt_i && bus.ihit) state_nxt = HALT;
      end
      ACCESS: begin
        bus.dmemREN   = req_ren;
        bus.dmemWEN   = req_wen;
        bus.dmemaddr  = req_addr;
        bus.dmemstore = req_store;
        if (bus.dhit) state_nxt = DONE;
      end
      DONE: begin
        bus.freeze_o = ~bus.ihit;
        if (bus.ihit) state_nxt = IDLE;
      end
      HALT: ;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.dmem_load_o = load_q;
  assign bus.halt_o      = (state == HALT);
  assign bus.stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: a per-cycle vector table plus reset,
// halt-exit and counter-saturation sequences.
module tb_dmem_access_ctrl;

  logic CLK = 1'b0;
  logic nRST;

  always #5 CLK = ~CLK;

  dmem_access_ctrl_if #(.WORD_W(32), .CNT_W(16)) bus ();
  dmem_access_ctrl_if #(.WORD_W(32), .CNT_W(4))  bus4 ();

  dmem_access_ctrl #(.CNT_W(16), .WORD_W(32)) u_dut (.CLK(CLK), .nRST(nRST), .bus(bus));
  dmem_access_ctrl #(.CNT_W(4),  .WORD_W(32)) u_sat (.CLK(CLK), .nRST(nRST), .bus(bus4));

  assign bus4.dmemREN_i   = bus.dmemREN_i;
  assign bus4.dmemWEN_i   = bus.dmemWEN_i;
  assign bus4.dmemaddr_i  = bus.dmemaddr_i;
  assign bus4.dmemstore_i = bus.dmemstore_i;
  assign bus4.halt_i      = bus.halt_i;
  assign bus4.ihit        = bus.ihit;
  assign bus4.dhit        = bus.dhit;
  assign bus4.dmemload    = bus.dmemload;

  typedef struct {
    logic        ren;
    logic        wen;
    logic        hlt;
    logic        ihit;
    logic        dhit;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] load;
    logic        e_ren;
    logic        e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_store;
    logic [31:0] e_load;
    logic        e_frz;
    logic        e_hlt;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ren, input logic wen, input logic hlt, input logic ih,
                       input logic dh, input logic [31:0] addr, input logic [31:0] st,
                       input logic [31:0] ld);
    bus.dmemREN_i   = ren;
    bus.dmemWEN_i   = wen;
    bus.halt_i      = hlt;
    bus.ihit        = ih;
    bus.dhit        = dh;
    bus.dmemaddr_i  = addr;
    bus.dmemstore_i = st;
    bus.dmemload    = ld;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // {ren,wen,hlt,ihit,dhit, addr,store,load, e_ren,e_wen,e_addr,e_store,e_load,e_frz,e_hlt,e_cnt}
    vq.push_back('{1'b0,1'b0,1'b0,1'b1,1'b0, 32'h0,   32'h0,    32'h0,        1'b0,1'b0,32'h0,  32'h0,   32'h0,        1'b0,1'b0,16'd0});
    vq.push_back('{1'b1,1'b0,1'b0,1'b1,1'b0, 32'h100, 32'h0,    32'h0,        1'b0,1'b0,32'h0,  32'h0,   32'h0,        1'b1,1'b0,16'd0});
    vq.push_back('{1'b1,1'b0,1'b0,1'b1,1'b0, 32'h100, 32'h0,    32'h0,        1'b1,1'b0,32'h100,32'h0,   32'h0,        1'b1,1'b0,16'd0});
    vq.push_back('{1'b1,1'b0,1'b0,1'b1,1'b1, 32'h100, 32'h0,    32'hDEADBEEF, 1'b1,1'b0,32'h100,32'h0,   32'h0,        1'b1,1'b0,16'd1});
    vq.push_back('{1'b1,1'b0,1'b0,1'b1,1'b0, 32'h100, 32'h0,    32'h0,        1'b0,1'b0,32'h0,  32'h0,   32'hDEADBEEF, 1'b0,1'b0,16'd2});
    vq.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0, 32'h200, 32'h1234, 32'h0,        1'b0,1'b0,32'h0,  32'h0,   32'hDEADBEEF, 1'b1,1'b0,16'd2});
    vq.push_back('{1'b0,1'b1,1'b0,1'b1,1'b1, 32'h200, 32'h1234, 32'hBAD0BAD0, 1'b0,1'b1,32'h200,32'h1234,32'hDEADBEEF, 1'b1,1'b0,16'd2});
    vq.push_back('{1'b0,1'b0,1'b0,1'b1,1'b0, 32'h0,   32'h0,    32'h0,        1'b0,1'b0,32'h0,  32'h0,   32'hDEADBEEF, 1'b0,1'b0,16'd3});
    vq.push_back('{1'b0,1'b0,1'b0,1'b1,1'b0, 32'h0,   32'h0,    32'h0,        1'b0,1'b0,32'h0,  32'h0,   32'hDEADBEEF, 1'b0,1'b0,16'd3});
    vq.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0, 32'h200, 32'h55,   32'h0,        1'b0,1'b0,32'h0,  32'h0,   32'hDEADBEEF, 1'b1,1'b0,16'd3});
    vq.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0, 32'h300, 32'h66,   32'h0,        1'b0,1'b1,32'h200,32'h55,  32'hDEADBEEF, 1'b1,1'b0,16'd3});
    vq.push_back('{1'b0,1'b1,1'b0,1'b1,1'b1, 32'h300, 32'h66,   32'h0,        1'b0,1'b1,32'h200,32'h55,  32'hDEADBEEF, 1'b1,1'b0,16'd4});
    for (int k = 0; k < 3; k++)
      vq.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0,    32'h0,        1'b0,1'b0,32'h0,  32'h0,   32'hDEADBEEF, 1'b1,1'b0,16'd5});
    vq.push_back('{1'b0,1'b0,1'b0,1'b1,1'b0, 32'h0,   32'h0,    32'h0,        1'b0,1'b0,32'h0,  32'h0,   32'hDEADBEEF, 1'b0,1'b0,16'd5});
    vq.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h0,    32'h0,        1'b0,1'b0,32'h0,  32'h0,   32'hDEADBEEF, 1'b1,1'b0,16'd5});
    vq.push_back('{1'b1,1'b1,1'b0,1'b1,1'b0, 32'h40,  32'h77,   32'h0,        1'b0,1'b0,32'h0,  32'h0,   32'hDEADBEEF, 1'b1,1'b0,16'd5});
    vq.push_back('{1'b1,1'b1,1'b0,1'b1,1'b1, 32'h40,  32'h77,   32'h11111111, 1'b0,1'b1,32'h40, 32'h77,  32'hDEADBEEF, 1'b1,1'b0,16'd5});
    vq.push_back('{1'b0,1'b0,1'b0,1'b1,1'b0, 32'h0,   32'h0,    32'h0,        1'b0,1'b0,32'h0,  32'h0,   32'hDEADBEEF, 1'b0,1'b0,16'd6});
    vq.push_back('{1'b0,1'b0,1'b0,1'b1,1'b1, 32'h0,   32'h0,    32'h2222,     1'b0,1'b0,32'h0,  32'h0,   32'hDEADBEEF, 1'b0,1'b0,16'd6});
    vq.push_back('{1'b1,1'b0,1'b0,1'b1,1'b0, 32'h104, 32'h0,    32'h0,        1'b0,1'b0,32'h0,  32'h0,   32'hDEADBEEF, 1'b1,1'b0,16'd6});
    vq.push_back('{1'b1,1'b0,1'b0,1'b1,1'b1, 32'h104, 32'h0,    32'hCAFEF00D, 1'b1,1'b0,32'h104,32'h0,   32'hDEADBEEF, 1'b1,1'b0,16'd6});
    vq.push_back('{1'b0,1'b0,1'b0,1'b1,1'b0, 32'h0,   32'h0,    32'h0,        1'b0,1'b0,32'h0,  32'h0,   32'hCAFEF00D, 1'b0,1'b0,16'd7});
    vq.push_back('{1'b1,1'b0,1'b1,1'b1,1'b0, 32'h108, 32'h0,    32'h0,        1'b0,1'b0,32'h0,  32'h0,   32'hCAFEF00D, 1'b1,1'b0,16'd7});
    vq.push_back('{1'b1,1'b0,1'b1,1'b1,1'b1, 32'h108, 32'h0,    32'h33,       1'b1,1'b0,32'h108,32'h0,   32'hCAFEF00D, 1'b1,1'b0,16'd7});
    vq.push_back('{1'b0,1'b0,1'b1,1'b1,1'b0, 32'h0,   32'h0,    32'h0,        1'b0,1'b0,32'h0,  32'h0,   32'h33,       1'b0,1'b0,16'd8});
    vq.push_back('{1'b0,1'b0,1'b1,1'b1,1'b0, 32'h0,   32'h0,    32'h0,        1'b0,1'b0,32'h0,  32'h0,   32'h33,       1'b0,1'b0,16'd8});
    vq.push_back('{1'b1,1'b0,1'b0,1'b1,1'b1, 32'h10C, 32'h0,    32'h44,       1'b0,1'b0,32'h0,  32'h0,   32'h33,       1'b1,1'b1,16'd8});
    vq.push_back('{1'b0,1'b0,1'b0,1'b1,1'b0, 32'h0,   32'h0,    32'h0,        1'b0,1'b0,32'h0,  32'h0,   32'h33,       1'b1,1'b1,16'd8});

    nRST = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    repeat (3) @(posedge CLK);
    #1 nRST = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].ren, vq[i].wen, vq[i].hlt, vq[i].ihit, vq[i].dhit,
            vq[i].addr, vq[i].store, vq[i].load);
      #3;
      chk($sformatf("row%0d.dmemREN", i),   {31'b0, bus.dmemREN},  {31'b0, vq[i].e_ren});
      chk($sformatf("row%0d.dmemWEN", i),   {31'b0, bus.dmemWEN},  {31'b0, vq[i].e_wen});
      chk($sformatf("row%0d.dmemaddr", i),  bus.dmemaddr,          vq[i].e_addr);
      chk($sformatf("row%0d.dmemstore", i), bus.dmemstore,         vq[i].e_store);
      chk($sformatf("row%0d.dmem_load", i), bus.dmem_load_o,       vq[i].e_load);
      chk($sformatf("row%0d.freeze", i),    {31'b0, bus.freeze_o}, {31'b0, vq[i].e_frz});
      chk($sformatf("row%0d.halt", i),      {31'b0, bus.halt_o},   {31'b0, vq[i].e_hlt});
      chk($sformatf("row%0d.stall_cnt", i), {16'b0, bus.stall_cnt_o}, {16'b0, vq[i].e_cnt});
      next_cycle();
    end

    // Reset leaves HALT; then a fresh load, and an asynchronous reset mid-ACCESS.
    nRST = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    #2;
    chk("rst.halt_clear", {31'b0, bus.halt_o}, 32'h0);
    next_cycle();
    nRST = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h400, 32'h0, 32'h0);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h400, 32'h0, 32'h5A5A5A5A);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    #2;
    chk("rld.dmem_load", bus.dmem_load_o, 32'h5A5A5A5A);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h500, 32'h0, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    #2;
    chk("mid.ren_before", {31'b0, bus.dmemREN}, 32'h1);
    chk("mid.addr_before", bus.dmemaddr, 32'h500);
    nRST = 1'b0;
    #1;
    chk("mid.ren_async",  {31'b0, bus.dmemREN},  32'h0);
    chk("mid.wen_async",  {31'b0, bus.dmemWEN},  32'h0);
    chk("mid.addr_async", bus.dmemaddr,          32'h0);
    chk("mid.load_async", bus.dmem_load_o,       32'h0);
    chk("mid.frz_async",  {31'b0, bus.freeze_o}, 32'h0);
    chk("mid.halt_async", {31'b0, bus.halt_o},   32'h0);
    chk("mid.cnt_async",  {16'b0, bus.stall_cnt_o}, 32'h0);
    next_cycle();

    // Long stall: the 4-bit counter must pin at 15 while the 16-bit one keeps counting.
    nRST = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h600, 32'h0, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    repeat (20) next_cycle();
    chk("sat.cnt4",  {28'b0, bus4.stall_cnt_o}, 32'd15);
    chk("sat.cnt16", {16'b0, bus.stall_cnt_o},  32'd20);
    chk("sat.ren_held", {31'b0, bus.dmemREN},   32'h1);
    chk("sat.addr_held", bus.dmemaddr,          32'h600);
    chk("sat.frz",  {31'b0, bus.freeze_o},      32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h77);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    #2;
    chk("sat.cnt4_after",  {28'b0, bus4.stall_cnt_o}, 32'd15);
    chk("sat.cnt16_after", {16'b0, bus.stall_cnt_o},  32'd21);
    chk("sat.load",        bus.dmem_load_o,           32'h77);
    chk("sat.done_frz",    {31'b0, bus.freeze_o},     32'h0);
    next_cycle();
    #2;
    chk("sat.idle_ren", {31'b0, bus.dmemREN}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
